// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide issue scheduler.
package muldiv_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 34;

    // Six bits covers a divide latency of up to 64 (load value DIV_LAT-1).
    localparam int CNT_W = 6;

    // funct3[2] selects the op class: 0 = multiply, 1 = divide/remainder.
    localparam int   OP_CLASS_BIT = 2;
    localparam logic OP_CLASS_MUL = 1'b0;
    localparam logic OP_CLASS_DIV = 1'b1;
endpackage

// File: rtl/muldiv_if.sv
// Decode/writeback-facing bundle of the multiply/divide scheduler.
interface muldiv_if;
    logic       issue_valid;
    logic [2:0] issue_op;
    logic [4:0] issue_rd;
    logic [4:0] issue_rs1;
    logic [4:0] issue_rs2;
    logic       stall_in;
    logic       div_zero;
    logic       wb_ack;
    logic       unit_start;
    logic [2:0] unit_op;
    logic       md_ready;
    logic       raw_hz;
    logic       result_valid;
    logic [4:0] result_rd;
    logic       busy;
    logic       ovf_err;

    modport master (
        output issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2,
        output stall_in, div_zero, wb_ack,
        input  unit_start, unit_op, md_ready, raw_hz, result_valid, result_rd, busy, ovf_err
    );

    modport slave (
        input  issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2,
        input  stall_in, div_zero, wb_ack,
        output unit_start, unit_op, md_ready, raw_hz, result_valid, result_rd, busy, ovf_err
    );
endinterface

// File: rtl/md_lat_counter.sv
// Latency down-counter: load, decrement-and-saturate at zero, or hold.
module md_lat_counter #(
    parameter int W = muldiv_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign zero = (cnt_reg == '0);
endmodule

// File: rtl/muldiv_scheduler.sv
// Issue scheduler for the M-extension unit: accepts one op at a time, times its latency,
// holds the result until writeback and flags RAW hazards back to decode.
module muldiv_scheduler #(
    parameter int MUL_LAT = muldiv_pkg::MUL_LAT_DEF,
    parameter int DIV_LAT = muldiv_pkg::DIV_LAT_DEF
) (
    input  logic    clk,
    input  logic    Rst,
    muldiv_if.slave bus
);
    import muldiv_pkg::*;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    md_state_t  state_reg;
    logic [2:0] op_reg;
    logic [4:0] rd_reg;
    logic       unit_start_reg;
    logic       ovf_err_reg;

    logic             md_ready_int;
    logic             accept;
    logic             ignored;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             div_abort;
    logic [CNT_W-1:0] load_val;

    assign md_ready_int = (state_reg == IDLE) || ((state_reg == DONE) && bus.wb_ack);
    assign accept       = bus.issue_valid && !bus.stall_in && md_ready_int;
    assign ignored      = bus.issue_valid && !bus.stall_in && !md_ready_int;
    assign load_val     = (bus.issue_op[OP_CLASS_BIT] == OP_CLASS_DIV) ? DIV_LOAD : MUL_LOAD;
    assign cnt_dec      = (state_reg == RUN) && !bus.stall_in;
    assign div_abort    = (op_reg[OP_CLASS_BIT] == OP_CLASS_DIV) && bus.div_zero;

    md_lat_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .srst     (Rst),
        .load     (accept),
        .load_val (load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_reg      <= IDLE;
            op_reg         <= '0;
            rd_reg         <= '0;
            unit_start_reg <= 1'b0;
            ovf_err_reg    <= 1'b0;
        end else begin
            unit_start_reg <= accept;
            if (ignored) begin
                ovf_err_reg <= 1'b1;
            end
            // An accept out of DONE skips IDLE entirely (back-to-back issue).
            if (accept) begin
                op_reg    <= bus.issue_op;
                rd_reg    <= bus.issue_rd;
                state_reg <= RUN;
            end else if (!bus.stall_in) begin
                case (state_reg)
                    RUN:     if (cnt_zero || div_abort) state_reg <= DONE;
                    DONE:    if (bus.wb_ack) state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Outputs are forced to their idle values for as long as reset is held.
    assign bus.md_ready     = Rst | md_ready_int;
    assign bus.unit_start   = unit_start_reg & ~Rst;
    assign bus.unit_op      = Rst ? 3'd0 : op_reg;
    assign bus.result_valid = (state_reg == DONE) & ~Rst;
    assign bus.result_rd    = Rst ? 5'd0 : rd_reg;
    assign bus.busy         = (state_reg != IDLE) & ~Rst;
    assign bus.ovf_err      = ovf_err_reg & ~Rst;
    assign bus.raw_hz       = ~Rst && (state_reg != IDLE) && (rd_reg != 5'd0)
                              && ((bus.issue_rs1 == rd_reg) || (bus.issue_rs2 == rd_reg));
endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed bench for muldiv_scheduler: latency, stall, div-by-zero, back-to-back, hazards, reset.
module tb_muldiv_scheduler;
    logic clk = 1'b0;
    logic Rst;
    int   checks = 0;
    int   failures = 0;

    muldiv_if bus();

    muldiv_scheduler #(.MUL_LAT(4), .DIV_LAT(34)) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0;
        bus.issue_op    = 3'd0;
        bus.issue_rd    = 5'd0;
        bus.issue_rs1   = 5'd0;
        bus.issue_rs2   = 5'd0;
        bus.stall_in    = 1'b0;
        bus.div_zero    = 1'b0;
        bus.wb_ack      = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] rd);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_rd    = rd;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        idle_inputs();
        bus.issue_valid = 1'b1;
        step();
        step();
        checks++; if (bus.md_ready !== 1'b1) begin failures++; $display("FAIL rst_md_ready: got %b required 1", bus.md_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL rst_result_valid: got %b required 0", bus.result_valid); end
        checks++; if (bus.unit_start !== 1'b0) begin failures++; $display("FAIL rst_unit_start: got %b required 0", bus.unit_start); end
        checks++; if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL rst_ovf_err: got %b required 0", bus.ovf_err); end
        Rst = 1'b0;
        bus.issue_valid = 1'b0;
        step();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_no_accept: busy got %b required 0", bus.busy); end
        $display("test_reset done");
    endtask

    task automatic test_mul();
        issue(3'd0, 5'd5);
        step();                                   // E0: accept
        bus.issue_valid = 1'b0;
        bus.div_zero    = 1'b1;                   // must not shorten a multiply
        checks++; if (bus.unit_start !== 1'b1) begin failures++; $display("FAIL mul_start: got %b required 1", bus.unit_start); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mul_busy: got %b required 1", bus.busy); end
        step();                                   // E1
        checks++; if (bus.unit_start !== 1'b0) begin failures++; $display("FAIL mul_start_pulse: got %b required 0", bus.unit_start); end
        step();
        step();                                   // E3
        bus.div_zero = 1'b0;
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL mul_early: result_valid got %b required 0 at E3", bus.result_valid); end
        step();                                   // E4
        checks++; if (bus.result_valid !== 1'b1) begin failures++; $display("FAIL mul_valid: got %b required 1 at E4", bus.result_valid); end
        checks++; if (bus.result_rd !== 5'd5) begin failures++; $display("FAIL mul_rd: got %0d required 5", bus.result_rd); end
        checks++; if (bus.md_ready !== 1'b0) begin failures++; $display("FAIL mul_done_ready: got %b required 0", bus.md_ready); end
        bus.issue_rs2 = 5'd5;
        #1;
        checks++; if (bus.raw_hz !== 1'b1) begin failures++; $display("FAIL raw_rs2: got %b required 1", bus.raw_hz); end
        bus.issue_rs2 = 5'd0;
        bus.issue_rs1 = 5'd4;
        #1;
        checks++; if (bus.raw_hz !== 1'b0) begin failures++; $display("FAIL raw_none: got %b required 0", bus.raw_hz); end
        bus.issue_rs1 = 5'd0;
        bus.wb_ack = 1'b1;
        #1;
        checks++; if (bus.md_ready !== 1'b1) begin failures++; $display("FAIL mul_ack_ready: got %b required 1", bus.md_ready); end
        step();
        bus.wb_ack = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mul_idle: busy got %b required 0", bus.busy); end
        checks++; if (bus.md_ready !== 1'b1) begin failures++; $display("FAIL mul_idle_ready: got %b required 1", bus.md_ready); end
        $display("test_mul done");
    endtask

    task automatic test_div();
        int seen = 0;
        issue(3'd4, 5'd7);
        step();                                   // E0
        bus.issue_valid = 1'b0;
        checks++; if (bus.unit_op !== 3'd4) begin failures++; $display("FAIL div_op: got %0d required 4", bus.unit_op); end
        for (int n = 1; n <= 40 && seen == 0; n++) begin
            step();
            if (bus.result_valid === 1'b1) seen = n;
        end
        checks++; if (seen != 34) begin failures++; $display("FAIL div_latency: got %0d required 34", seen); end
        checks++; if (bus.result_rd !== 5'd7) begin failures++; $display("FAIL div_rd: got %0d required 7", bus.result_rd); end
        bus.wb_ack = 1'b1;
        step();
        bus.wb_ack = 1'b0;
        // Divide by zero: flag present in the cycle before E2 ends the op at E2.
        issue(3'd5, 5'd7);
        step();                                   // E0
        bus.issue_valid = 1'b0;
        step();                                   // E1
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL dz_early: got %b required 0 at E1", bus.result_valid); end
        bus.div_zero = 1'b1;
        step();                                   // E2
        bus.div_zero = 1'b0;
        checks++; if (bus.result_valid !== 1'b1) begin failures++; $display("FAIL dz_valid: got %b required 1 at E2", bus.result_valid); end
        bus.wb_ack = 1'b1;
        step();
        bus.wb_ack = 1'b0;
        $display("test_div done");
    endtask

    task automatic test_stall();
        issue(3'd0, 5'd3);
        step();                                   // E0
        bus.issue_valid = 1'b0;
        step();                                   // E1
        bus.stall_in = 1'b1;
        issue(3'd1, 5'd11);
        step();
        step();
        step();                                   // E2..E4 frozen
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL stall_busy: got %b required 1", bus.busy); end
        checks++; if (bus.unit_start !== 1'b0) begin failures++; $display("FAIL stall_no_start: got %b required 0", bus.unit_start); end
        bus.stall_in = 1'b0;
        bus.issue_valid = 1'b0;
        step();
        step();                                   // E6
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL stall_early: got %b required 0 at E6", bus.result_valid); end
        step();                                   // E7
        checks++; if (bus.result_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b required 1 at E7", bus.result_valid); end
        checks++; if (bus.result_rd !== 5'd3) begin failures++; $display("FAIL stall_rd: got %0d required 3", bus.result_rd); end
        checks++; if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL stall_ovf: got %b required 0", bus.ovf_err); end
        $display("test_stall done");
    endtask

    task automatic test_back_to_back();
        bus.wb_ack = 1'b1;
        issue(3'd1, 5'd9);
        #1;
        checks++; if (bus.md_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b required 1", bus.md_ready); end
        step();                                   // E0
        bus.wb_ack = 1'b0;
        bus.issue_valid = 1'b0;
        checks++; if (bus.unit_start !== 1'b1) begin failures++; $display("FAIL b2b_start: got %b required 1", bus.unit_start); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b required 1", bus.busy); end
        checks++; if (bus.unit_op !== 3'd1) begin failures++; $display("FAIL b2b_op: got %0d required 1", bus.unit_op); end
        step();
        step();
        step();                                   // E3
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL b2b_early: got %b required 0 at E3", bus.result_valid); end
        step();                                   // E4
        checks++; if (bus.result_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %b required 1 at E4", bus.result_valid); end
        checks++; if (bus.result_rd !== 5'd9) begin failures++; $display("FAIL b2b_rd: got %0d required 9", bus.result_rd); end
        bus.wb_ack = 1'b1;
        step();
        bus.wb_ack = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_rd_zero();
        issue(3'd3, 5'd0);
        step();                                   // E0
        bus.issue_valid = 1'b0;
        #1;
        checks++; if (bus.raw_hz !== 1'b0) begin failures++; $display("FAIL rd0_raw_run: got %b required 0", bus.raw_hz); end
        step();
        step();
        step();
        step();                                   // E4
        checks++; if (bus.result_valid !== 1'b1) begin failures++; $display("FAIL rd0_valid: got %b required 1", bus.result_valid); end
        checks++; if (bus.result_rd !== 5'd0) begin failures++; $display("FAIL rd0_rd: got %0d required 0", bus.result_rd); end
        checks++; if (bus.raw_hz !== 1'b0) begin failures++; $display("FAIL rd0_raw_done: got %b required 0", bus.raw_hz); end
        bus.wb_ack = 1'b1;
        step();
        bus.wb_ack = 1'b0;
        $display("test_rd_zero done");
    endtask

    task automatic test_ovf();
        issue(3'd2, 5'd6);
        step();                                   // E0
        bus.issue_valid = 1'b0;
        step();                                   // E1
        issue(3'd4, 5'd12);
        #1;
        checks++; if (bus.md_ready !== 1'b0) begin failures++; $display("FAIL ovf_ready: got %b required 0", bus.md_ready); end
        step();                                   // E2: ignored issue
        bus.issue_valid = 1'b0;
        checks++; if (bus.ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b required 1", bus.ovf_err); end
        checks++; if (bus.unit_op !== 3'd2) begin failures++; $display("FAIL ovf_op_kept: got %0d required 2", bus.unit_op); end
        checks++; if (bus.unit_start !== 1'b0) begin failures++; $display("FAIL ovf_no_start: got %b required 0", bus.unit_start); end
        step();
        step();                                   // E4
        checks++; if (bus.result_rd !== 5'd6) begin failures++; $display("FAIL ovf_rd: got %0d required 6", bus.result_rd); end
        bus.wb_ack = 1'b1;
        step();
        bus.wb_ack = 1'b0;
        checks++; if (bus.ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b required 1", bus.ovf_err); end
        $display("test_ovf done");
    endtask

    task automatic test_reset_mid_run();
        int late_valid = 0;
        issue(3'd6, 5'd8);
        step();                                   // E0
        bus.issue_valid = 1'b0;
        for (int n = 0; n < 5; n++) step();
        Rst = 1'b1;
        #1;
        checks++; if (bus.md_ready !== 1'b1) begin failures++; $display("FAIL rrun_ready: got %b required 1", bus.md_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rrun_busy_held: got %b required 0", bus.busy); end
        step();
        Rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rrun_busy: got %b required 0", bus.busy); end
        checks++; if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL rrun_ovf: got %b required 0", bus.ovf_err); end
        checks++; if (bus.unit_op !== 3'd0) begin failures++; $display("FAIL rrun_op: got %0d required 0", bus.unit_op); end
        for (int n = 0; n < 40; n++) begin
            step();
            if (bus.result_valid !== 1'b0) late_valid++;
        end
        checks++; if (late_valid != 0) begin failures++; $display("FAIL rrun_no_result: got %0d valid cycles required 0", late_valid); end
        $display("test_reset_mid_run done");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_stall();
        test_back_to_back();
        test_rd_zero();
        test_ovf();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_scheduler.md
MULDIV_SCHEDULER -- requirements
Module: muldiv_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk (input, 1, rising-edge system clock) and Rst (input, 1, synchronous active-high reset), listed first.
REQ-002 Parameters SHALL be:
- MUL_LAT, default 4, multiply latency in cycles.
- DIV_LAT, default 34, divide latency in cycles.
REQ-003 Ports SHALL be:
- issue_valid, input, 1: decode presents an M-extension op.
- issue_op, input, 3: funct3 of the op; 0-3 multiply, 4-7 divide/remainder.
- issue_rd, input, 5: destination register.
- issue_rs1, input, 5: source register of the instruction in decode.
- issue_rs2, input, 5: source register of the instruction in decode.
- stall_in, input, 1: pipeline freeze (dbg OR mem_hold).
- div_zero, input, 1: divisor-zero flag from the unit.
- wb_ack, input, 1: writeback consumed the result.
- unit_start, output, 1: one-cycle start pulse to the multiply/divide unit.
- unit_op, output, 3: latched op.
- md_ready, output, 1: unit can accept an issue.
- raw_hz, output, 1: decode source register depends on a pending result.
- result_valid, output, 1: result available.
- result_rd, output, 5: destination register of the result.
- busy, output, 1: state is not IDLE.
- ovf_err, output, 1: sticky protocol error.

Function
REQ-004 The block SHALL implement the states IDLE, RUN and DONE.
REQ-005 In IDLE, when issue_valid=1 and stall_in=0, the block SHALL latch issue_op and issue_rd, pulse unit_start for exactly that cycle, load cnt with (MUL_LAT-1) for multiply or (DIV_LAT-1) for divide, and enter RUN.
REQ-006 In RUN with stall_in=0, cnt SHALL decrement every cycle; when cnt=0 the block SHALL enter DONE on the next edge, so result_valid rises exactly LAT edges after the accept edge.
REQ-007 In RUN with a divide op, div_zero=1 with stall_in=0 SHALL force DONE on the next edge regardless of cnt.
REQ-008 stall_in=1 SHALL freeze state, cnt and all latched fields, and SHALL suppress any accept.
REQ-009 In DONE, result_valid SHALL be 1 and result_rd SHALL equal the latched rd. On wb_ack=1 with stall_in=0, the block SHALL go to IDLE, or, if issue_valid=1 in the same cycle, directly accept the new op (back-to-back, same actions as REQ-005).
REQ-010 md_ready SHALL be combinational: 1 when state=IDLE, or when state=DONE and wb_ack=1; 0 otherwise.
REQ-011 raw_hz SHALL be combinational: 1 when state is RUN or DONE, latched rd is not 0, and issue_rs1 or issue_rs2 equals latched rd; 0 otherwise.
REQ-012 An issue with rd=0 SHALL execute normally and produce result_valid with result_rd=0; it SHALL never raise raw_hz.
REQ-013 issue_valid=1 with md_ready=0 and stall_in=0 SHALL be ignored and SHALL set ovf_err, which stays set until reset.
REQ-014 cnt SHALL be 6 bits wide, SHALL never wrap below 0, and DIV_LAT SHALL be at most 64.
REQ-015 unit_op SHALL hold the latched op from accept until the next accept.

Reset
REQ-016 Rst=1 at a clock edge SHALL force state=IDLE, cnt=0, latched op=0, latched rd=0 and ovf_err=0.
REQ-017 While reset is applied, all outputs SHALL be 0 except md_ready, which SHALL be 1.
REQ-018 Reset mid-RUN or mid-DONE SHALL discard the pending op with no result_valid afterwards.
REQ-019 Rst SHALL take priority over stall_in and issue_valid.

Structure
REQ-020 A shared package muldiv_pkg SHALL hold the state enum (IDLE/RUN/DONE), the MUL_LAT/DIV_LAT defaults, and op-class decode constants (MUL when op[2]=0, DIV when op[2]=1).
REQ-021 A single sub-module md_lat_counter (load, decrement, hold, zero flag) SHALL implement cnt; all other logic SHALL stay in muldiv_scheduler.

Verification
REQ-022 The bench SHALL cover:
- MUL op=0, rd=5 issued at edge E0 -> unit_start high one cycle; result_valid=1, result_rd=5 from E4; wb_ack -> IDLE, md_ready=1.
- DIV op=4, rd=7, no div_zero -> result_valid from E34; with div_zero=1 in the first RUN cycle -> result_valid at E2.
- stall_in held 3 cycles mid-RUN of a MUL -> result_valid delayed to E7; issue during stall not accepted.
- DONE with wb_ack=1 and a simultaneous MUL issue, rd=9 -> direct RUN, unit_start pulse, no IDLE cycle, result_rd=9 four edges later.
- pending rd=5 with issue_rs2=5 -> raw_hz=1; pending rd=0 with issue_rs1=0 -> raw_hz=0; issue during RUN -> ignored, ovf_err=1.
- Rst during RUN of a DIV -> next cycle state IDLE, busy=0, ovf_err=0, no result_valid afterwards.
